// File: rtl/taxi_mac_pause_pkg.sv
// Shared constants and types for the RX pause controller.
// Quanta are 512 bit times; timers carry QFB fractional bits.
package taxi_mac_pause_pkg;

  localparam logic [15:0] MCF_OPC_LFC = 16'h0001;
  localparam logic [15:0] MCF_OPC_PFC = 16'h0101;
  localparam logic [15:0] MCF_ETYPE   = 16'h8808;

  localparam int QUANTA_BITS = 512;
  localparam int PFC_CLASSES = 8;
  localparam int QFB_DEF     = 8;

  typedef logic [16+QFB_DEF-1:0] pause_timer_t;

  // Quanta fields arrive big-endian, high byte first.
  function automatic logic [15:0] be16(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/taxi_mac_pause_timer.sv
// One pause-quanta countdown timer with a registered request.
// Load beats countdown; countdown saturates at zero.
module taxi_mac_pause_timer
  import taxi_mac_pause_pkg::*;
#(
  parameter int QFB = QFB_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] quanta,
  input  logic [15:0] step,
  input  logic        ack,
  output logic        req
);

  localparam int TW = 16 + QFB;

  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;
  logic [TW-1:0] stp;

  assign stp = TW'(step);

  always_comb begin
    tmr_nxt = tmr;
    if (!en) begin
      tmr_nxt = '0;
    end else if (load) begin
      tmr_nxt = {quanta, {QFB{1'b0}}};
    end else if (req && ack) begin
      tmr_nxt = (tmr > stp) ? (tmr - stp) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
      req <= 1'b0;
    end else begin
      tmr <= tmr_nxt;
      req <= (tmr_nxt != '0);
    end
  end

endmodule

// File: rtl/taxi_mac_pause_ctrl_rx.sv
// RX pause controller: LFC/PFC frame decode and per-class timers.
// Statistics exist only when TAXI_MAC_PAUSE_RX_STAT_EN is defined.
module taxi_mac_pause_ctrl_rx
  import taxi_mac_pause_pkg::*;
#(
  parameter int MCF_PARAMS_SIZE = 18,
  parameter bit PFC_EN          = 1'b1,
  parameter int QFB             = QFB_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mcf_valid,
  input  logic [15:0]                  mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  output logic                         rx_lfc_req,
  input  logic                         rx_lfc_ack,
  output logic [7:0]                   rx_pfc_req,
  input  logic [7:0]                   rx_pfc_ack,
  input  logic [15:0]                  cfg_rx_lfc_opcode,
  input  logic                         cfg_rx_lfc_en,
  input  logic [15:0]                  cfg_rx_pfc_opcode,
  input  logic                         cfg_rx_pfc_en,
  input  logic [15:0]                  cfg_rx_quanta_step,
  output logic                         stat_rx_lfc_pkt,
  output logic                         stat_rx_lfc_xon,
  output logic                         stat_rx_lfc_xoff,
  output logic                         stat_rx_lfc_paused,
  output logic                         stat_rx_pfc_pkt,
  output logic [7:0]                   stat_rx_pfc_xon,
  output logic [7:0]                   stat_rx_pfc_xoff,
  output logic [7:0]                   stat_rx_pfc_paused
);

  logic                         lfc_acc;
  logic                         pfc_acc;
  logic [15:0]                  lfc_q;
  logic [7:0]                   pfc_e;
  logic [PFC_CLASSES-1:0][15:0] pfc_q;

  assign lfc_acc = mcf_valid && cfg_rx_lfc_en &&
                   (mcf_opcode == cfg_rx_lfc_opcode);
  assign pfc_acc = PFC_EN && mcf_valid && cfg_rx_pfc_en &&
                   (mcf_opcode == cfg_rx_pfc_opcode);

  assign lfc_q = be16(mcf_params[7:0], mcf_params[15:8]);
  // Byte 0 of a PFC frame is reserved; byte 1 is the class mask.
  assign pfc_e = pfc_acc ? mcf_params[15:8] : 8'h00;

  taxi_mac_pause_timer #(
    .QFB(QFB)
  ) u_lfc (
    .clk   (clk),
    .rst   (rst),
    .en    (cfg_rx_lfc_en),
    .load  (lfc_acc),
    .quanta(lfc_q),
    .step  (cfg_rx_quanta_step),
    .ack   (rx_lfc_ack),
    .req   (rx_lfc_req)
  );

  if (PFC_EN) begin : g_pfc
    for (genvar i = 0; i < PFC_CLASSES; i++) begin : g_cls
      assign pfc_q[i] = be16(mcf_params[8*(2+2*i) +: 8],
                             mcf_params[8*(3+2*i) +: 8]);

      taxi_mac_pause_timer #(
        .QFB(QFB)
      ) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .en    (cfg_rx_pfc_en),
        .load  (pfc_e[i]),
        .quanta(pfc_q[i]),
        .step  (cfg_rx_quanta_step),
        .ack   (rx_pfc_ack[i]),
        .req   (rx_pfc_req[i])
      );
    end
  end else begin : g_no_pfc
    logic unused_pfc;
    assign pfc_q      = '0;
    assign rx_pfc_req = '0;
    assign unused_pfc = ^{rx_pfc_ack, cfg_rx_pfc_en,
                          cfg_rx_pfc_opcode, pfc_q,
                          pfc_e, pfc_acc};
  end

`ifdef TAXI_MAC_PAUSE_RX_STAT_EN
  logic [7:0] pfc_xon_c;
  logic [7:0] pfc_xoff_c;

  always_comb begin
    pfc_xon_c  = '0;
    pfc_xoff_c = '0;
    for (int i = 0; i < PFC_CLASSES; i++) begin
      pfc_xon_c[i]  = pfc_e[i] && (pfc_q[i] == 16'h0);
      pfc_xoff_c[i] = pfc_e[i] && (pfc_q[i] != 16'h0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rx_lfc_pkt    <= 1'b0;
      stat_rx_lfc_xon    <= 1'b0;
      stat_rx_lfc_xoff   <= 1'b0;
      stat_rx_lfc_paused <= 1'b0;
      stat_rx_pfc_pkt    <= 1'b0;
      stat_rx_pfc_xon    <= '0;
      stat_rx_pfc_xoff   <= '0;
      stat_rx_pfc_paused <= '0;
    end else begin
      stat_rx_lfc_pkt    <= lfc_acc;
      stat_rx_lfc_xon    <= lfc_acc && (lfc_q == 16'h0);
      stat_rx_lfc_xoff   <= lfc_acc && (lfc_q != 16'h0);
      stat_rx_lfc_paused <= rx_lfc_req && rx_lfc_ack;
      stat_rx_pfc_pkt    <= pfc_acc;
      stat_rx_pfc_xon    <= pfc_xon_c;
      stat_rx_pfc_xoff   <= pfc_xoff_c;
      stat_rx_pfc_paused <= rx_pfc_req & rx_pfc_ack;
    end
  end
`else
  assign stat_rx_lfc_pkt    = 1'b0;
  assign stat_rx_lfc_xon    = 1'b0;
  assign stat_rx_lfc_xoff   = 1'b0;
  assign stat_rx_lfc_paused = 1'b0;
  assign stat_rx_pfc_pkt    = 1'b0;
  assign stat_rx_pfc_xon    = '0;
  assign stat_rx_pfc_xoff   = '0;
  assign stat_rx_pfc_paused = '0;
`endif

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_rx.sv
// Bench for taxi_mac_pause_ctrl_rx: vector table, corner sequences
// and randomized frames against a quanta-arithmetic model.
module tb_taxi_mac_pause_ctrl_rx;

  localparam int PB = 18;
  localparam int PW = PB * 8;
  localparam longint unsigned ONE_Q = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mcf_valid = 1'b0;
  logic [15:0]   mcf_opcode = '0;
  logic [PW-1:0] mcf_params = '0;
  logic          rx_lfc_req;
  logic          rx_lfc_ack = 1'b1;
  logic [7:0]    rx_pfc_req;
  logic [7:0]    rx_pfc_ack = 8'hFF;
  logic [15:0]   cfg_rx_lfc_opcode = 16'h0001;
  logic          cfg_rx_lfc_en = 1'b1;
  logic [15:0]   cfg_rx_pfc_opcode = 16'h0101;
  logic          cfg_rx_pfc_en = 1'b1;
  logic [15:0]   cfg_rx_quanta_step = 16'h0020;
  logic          stat_rx_lfc_pkt;
  logic          stat_rx_lfc_xon;
  logic          stat_rx_lfc_xoff;
  logic          stat_rx_lfc_paused;
  logic          stat_rx_pfc_pkt;
  logic [7:0]    stat_rx_pfc_xon;
  logic [7:0]    stat_rx_pfc_xoff;
  logic [7:0]    stat_rx_pfc_paused;

  int tests = 0;
  int fails = 0;

  // Model: index 0..7 are PFC classes, 8 is the link timer.
  longint unsigned mt[9];
  bit              mreq[9];

  taxi_mac_pause_ctrl_rx dut (
    .clk               (clk),
    .rst               (rst),
    .mcf_valid         (mcf_valid),
    .mcf_opcode        (mcf_opcode),
    .mcf_params        (mcf_params),
    .rx_lfc_req        (rx_lfc_req),
    .rx_lfc_ack        (rx_lfc_ack),
    .rx_pfc_req        (rx_pfc_req),
    .rx_pfc_ack        (rx_pfc_ack),
    .cfg_rx_lfc_opcode (cfg_rx_lfc_opcode),
    .cfg_rx_lfc_en     (cfg_rx_lfc_en),
    .cfg_rx_pfc_opcode (cfg_rx_pfc_opcode),
    .cfg_rx_pfc_en     (cfg_rx_pfc_en),
    .cfg_rx_quanta_step(cfg_rx_quanta_step),
    .stat_rx_lfc_pkt   (stat_rx_lfc_pkt),
    .stat_rx_lfc_xon   (stat_rx_lfc_xon),
    .stat_rx_lfc_xoff  (stat_rx_lfc_xoff),
    .stat_rx_lfc_paused(stat_rx_lfc_paused),
    .stat_rx_pfc_pkt   (stat_rx_pfc_pkt),
    .stat_rx_pfc_xon   (stat_rx_pfc_xon),
    .stat_rx_pfc_xoff  (stat_rx_pfc_xoff),
    .stat_rx_pfc_paused(stat_rx_pfc_paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] lfcp(input logic [15:0] q);
    logic [PW-1:0] p;
    p = '0;
    p[7:0]  = q[15:8];
    p[15:8] = q[7:0];
    return p;
  endfunction

  function automatic logic [PW-1:0] pfcp(input logic [7:0] e,
                                         input logic [7:0][15:0] q);
    logic [PW-1:0] p;
    p = '0;
    p[15:8] = e;
    for (int i = 0; i < 8; i++) begin
      p[8*(2+2*i) +: 8] = q[i][15:8];
      p[8*(3+2*i) +: 8] = q[i][7:0];
    end
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) begin
      mt[i]   = 0;
      mreq[i] = 1'b0;
    end
  endtask

  // Advance one clock; model predicts from the inputs seen at the edge.
  task automatic cycle();
    longint unsigned nt[9];
    longint unsigned stp;
    bit en, ld, ak, lacc, pacc;
    logic [15:0] q;
    logic [7:0] e, xpreq;
    bit x_lpkt, x_lxon, x_lxoff, x_lpau, x_ppkt;
    bit [7:0] x_pxon, x_pxoff, x_ppau;
    stp  = longint'(cfg_rx_quanta_step);
    lacc = mcf_valid && cfg_rx_lfc_en &&
           mcf_opcode == cfg_rx_lfc_opcode;
    pacc = mcf_valid && cfg_rx_pfc_en &&
           mcf_opcode == cfg_rx_pfc_opcode;
    e = mcf_params[15:8];
    x_lxon = 0; x_lxoff = 0; x_lpau = 0;
    x_pxon = '0; x_pxoff = '0; x_ppau = '0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        en = cfg_rx_lfc_en; ld = lacc; ak = rx_lfc_ack;
        q  = {mcf_params[7:0], mcf_params[15:8]};
      end else begin
        en = cfg_rx_pfc_en; ld = pacc && e[i]; ak = rx_pfc_ack[i];
        q  = {mcf_params[8*(2+2*i) +: 8], mcf_params[8*(3+2*i) +: 8]};
      end
      if (!en) nt[i] = 0;
      else if (ld) nt[i] = longint'(q) * ONE_Q;
      else if (mreq[i] && ak) nt[i] = (mt[i] > stp) ? mt[i] - stp : 0;
      else nt[i] = mt[i];
      if (i == 8) begin
        x_lxon  = ld && q == 0;
        x_lxoff = ld && q != 0;
        x_lpau  = mreq[8] && ak;
      end else begin
        x_pxon[i]  = ld && q == 0;
        x_pxoff[i] = ld && q != 0;
        x_ppau[i]  = mreq[i] && ak;
      end
    end
    x_lpkt = lacc;
    x_ppkt = pacc;
`ifndef TAXI_MAC_PAUSE_RX_STAT_EN
    x_lpkt = 0; x_lxon = 0; x_lxoff = 0; x_lpau = 0; x_ppkt = 0;
    x_pxon = '0; x_pxoff = '0; x_ppau = '0;
`endif
    @(posedge clk);
    #1;
    xpreq = '0;
    for (int i = 0; i < 9; i++) begin
      mt[i]   = nt[i];
      mreq[i] = nt[i] != 0;
      if (i < 8) xpreq[i] = mreq[i];
    end
    chk("model_lfc_req", 64'(rx_lfc_req), 64'(mreq[8]));
    chk("model_pfc_req", 64'(rx_pfc_req), 64'(xpreq));
    chk("model_lfc_stat",
        64'({stat_rx_lfc_pkt, stat_rx_lfc_xon,
             stat_rx_lfc_xoff, stat_rx_lfc_paused}),
        64'({x_lpkt, x_lxon, x_lxoff, x_lpau}));
    chk("model_pfc_stat",
        64'({stat_rx_pfc_pkt, stat_rx_pfc_xon,
             stat_rx_pfc_xoff, stat_rx_pfc_paused}),
        64'({x_ppkt, x_pxon, x_pxoff, x_ppau}));
  endtask

  task automatic send(input logic [15:0] op, input logic [PW-1:0] p);
    mcf_valid  = 1'b1;
    mcf_opcode = op;
    mcf_params = p;
    cycle();
    mcf_valid  = 1'b0;
    mcf_params = '0;
  endtask

  task automatic do_reset();
    mcf_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req", 64'({rx_lfc_req, rx_pfc_req}), 64'h0);
    chk("reset_stat",
        64'({stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff,
             stat_rx_lfc_paused, stat_rx_pfc_pkt, stat_rx_pfc_xon,
             stat_rx_pfc_xoff, stat_rx_pfc_paused}), 64'h0);
  endtask

  typedef struct {
    logic [15:0]   op;
    logic [PW-1:0] prm;
    bit            len;
    bit            pen;
    bit            lreq;
    logic [7:0]    preq;
  } vec_t;

  vec_t vt[9];

  initial begin
    int n;
    logic [7:0][15:0] qv;

    qv = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h7, 16'h2};
    vt[0] = '{16'h0001, lfcp(16'h0010), 1, 1, 1, 8'h00};
    vt[1] = '{16'h0001, lfcp(16'h0000), 1, 1, 0, 8'h00};
    vt[2] = '{16'h0101, pfcp(8'h05, qv), 1, 1, 0, 8'h05};
    vt[3] = '{16'h0002, lfcp(16'h0010), 1, 1, 0, 8'h00};
    vt[4] = '{16'h0001, lfcp(16'h0010), 0, 1, 0, 8'h00};
    qv = {8{16'h0001}};
    vt[5] = '{16'h0101, pfcp(8'hFF, qv), 1, 1, 0, 8'hFF};
    qv = {16'h3, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    vt[6] = '{16'h0101, pfcp(8'h80, qv), 1, 1, 0, 8'h80};
    qv = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5, 16'h0};
    vt[7] = '{16'h0101, pfcp(8'h03, qv), 1, 1, 0, 8'h02};
    qv = {8{16'h0001}};
    vt[8] = '{16'h0101, pfcp(8'hFF, qv), 1, 0, 0, 8'h00};

    model_clear();
    do_reset();

    for (int v = 0; v < 9; v++) begin
      do_reset();
      cfg_rx_lfc_en = vt[v].len;
      cfg_rx_pfc_en = vt[v].pen;
      send(vt[v].op, vt[v].prm);
      chk($sformatf("vec%0d_lfc", v), 64'(rx_lfc_req), 64'(vt[v].lreq));
      chk($sformatf("vec%0d_pfc", v), 64'(rx_pfc_req), 64'(vt[v].preq));
    end
    cfg_rx_lfc_en = 1'b1;
    cfg_rx_pfc_en = 1'b1;

    // XOFF of 16 quanta at 1/8 quanta per clock lasts 128 clocks.
    do_reset();
    cfg_rx_quanta_step = 16'h0020;
    send(16'h0001, lfcp(16'h0010));
    chk("t1_req_up", 64'(rx_lfc_req), 64'h1);
`ifdef TAXI_MAC_PAUSE_RX_STAT_EN
    chk("t1_xoff_pulse", 64'(stat_rx_lfc_xoff), 64'h1);
`endif
    n = 1;
    for (int k = 0; k < 1000 && rx_lfc_req; k++) begin
      cycle();
`ifdef TAXI_MAC_PAUSE_RX_STAT_EN
      if (k == 0) chk("t1_xoff_once", 64'(stat_rx_lfc_xoff), 64'h0);
`endif
      if (rx_lfc_req) n++;
    end
    chk("t1_len", 64'(n), 64'd128);

    // XON cancels a pause in progress.
    do_reset();
    send(16'h0001, lfcp(16'h0100));
    repeat (9) cycle();
    chk("t2_before_xon", 64'(rx_lfc_req), 64'h1);
    send(16'h0001, lfcp(16'h0000));
    chk("t2_after_xon", 64'(rx_lfc_req), 64'h0);
`ifdef TAXI_MAC_PAUSE_RX_STAT_EN
    chk("t2_xon_pulse", 64'(stat_rx_lfc_xon), 64'h1);
`endif

    // No countdown while TX has not acknowledged.
    do_reset();
    cfg_rx_quanta_step = 16'h0100;
    rx_lfc_ack = 1'b0;
    send(16'h0001, lfcp(16'h0001));
    for (int k = 0; k < 50; k++) begin
      chk("t3_hold", 64'(rx_lfc_req), 64'h1);
      if (k < 49) cycle();
    end
    rx_lfc_ack = 1'b1;
    cycle();
    chk("t3_drop", 64'(rx_lfc_req), 64'h0);

    // PFC mask selects classes 0 and 2 only.
    do_reset();
    rx_pfc_ack = 8'hFF;
    qv = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h2};
    send(16'h0101, pfcp(8'h05, qv));
    chk("t4_load", 64'(rx_pfc_req), 64'h05);
    cycle();
    chk("t4_one", 64'(rx_pfc_req), 64'h05);
    cycle();
    chk("t4_two", 64'(rx_pfc_req), 64'h04);

    // Reload on the cycle of expiry keeps the request up.
    do_reset();
    send(16'h0001, lfcp(16'h0001));
    chk("t5_first", 64'(rx_lfc_req), 64'h1);
    send(16'h0001, lfcp(16'h0004));
    chk("t5_reload", 64'(rx_lfc_req), 64'h1);
    repeat (3) cycle();
    chk("t5_still", 64'(rx_lfc_req), 64'h1);
    cycle();
    chk("t5_expire", 64'(rx_lfc_req), 64'h0);

    // Disabled LFC ignores frames; reset drops the request at once.
    do_reset();
    cfg_rx_lfc_en = 1'b0;
    send(16'h0001, lfcp(16'h0010));
    chk("t6_dis_req", 64'(rx_lfc_req), 64'h0);
    chk("t6_dis_pkt", 64'(stat_rx_lfc_pkt), 64'h0);
    cfg_rx_lfc_en = 1'b1;
    send(16'h0001, lfcp(16'h0100));
    chk("t6_paused", 64'(rx_lfc_req), 64'h1);
    rst = 1'b1;
    #1;
    chk("t6_async_rst", 64'(rx_lfc_req), 64'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized frames, enables, acks and step sizes.
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [15:0] op;
      r = int'($urandom_range(0, 9));
      op = (r < 4) ? 16'h0001 : (r < 8) ? 16'h0101 : 16'(r);
      for (int i = 0; i < 8; i++) begin
        qv[i] = ($urandom_range(0, 3) == 0) ? 16'h0 :
                16'($urandom_range(1, 8));
      end
      mcf_valid  = ($urandom_range(0, 7) == 0);
      mcf_opcode = op;
      mcf_params = pfcp(8'($urandom), qv);
      if (op == 16'h0001) mcf_params = lfcp(qv[0]);
      cfg_rx_lfc_en = ($urandom_range(0, 63) != 0);
      cfg_rx_pfc_en = ($urandom_range(0, 63) != 0);
      rx_lfc_ack = ($urandom_range(0, 3) != 0);
      rx_pfc_ack = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        r = int'($urandom_range(0, 3));
        cfg_rx_quanta_step = (r == 0) ? 16'h0020 :
                             (r == 1) ? 16'h0100 :
                             (r == 2) ? 16'hFFFF : 16'($urandom);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
